// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode and operand-fetch pipeline register (ID/EX)
//
// Decodes one RV32I instruction per capture, selects ALU operands (with optional
// forwarding from a downstream writer) and registers the result for the EX stage.
//
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   in_valid / in_ready             upstream handshake (in_ready is combinational)
//   instr, pc                       instruction word and its address
//   rs1_data, rs2_data              register-file read data
//   fwd_we, fwd_rd, fwd_data        downstream write-back for operand forwarding
//   flush                           kill held and incoming instruction
//   out_valid / out_ready           downstream handshake
//   alu_in1, alu_in2, aluop         ALU operands and operation
//   rd, funct3, store_data          destination, funct3 and store value
//   reg_we, mem_re, mem_we, illegal control flags
module id_ex_stage #(
  parameter int unsigned FWD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        fwd_we,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  aluop,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        illegal,
  output logic [2:0]  funct3,
  output logic [31:0] store_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic        is_shift;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign rd_idx   = instr[11:7];
  assign rs1_idx  = instr[19:15];
  assign rs2_idx  = instr[24:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Operand fetch: x0 reads as zero; a matching downstream write wins over the RF.
  logic        fwd_ok;
  logic [31:0] op1;
  logic [31:0] op2;

  assign fwd_ok = (FWD_EN != 0) && fwd_we && (fwd_rd != 5'd0);

  always_comb begin
    op1 = rs1_data;
    if (rs1_idx == 5'd0) begin
      op1 = '0;
    end else if (fwd_ok && (fwd_rd == rs1_idx)) begin
      op1 = fwd_data;
    end
    op2 = rs2_data;
    if (rs2_idx == 5'd0) begin
      op2 = '0;
    end else if (fwd_ok && (fwd_rd == rs2_idx)) begin
      op2 = fwd_data;
    end
  end

  // Decode
  logic [31:0] dec_in1;
  logic [31:0] dec_in2;
  logic [31:0] dec_store;
  logic [3:0]  dec_aluop;
  logic        dec_we;
  logic        dec_re;
  logic        dec_wm;
  logic        dec_ill;

  always_comb begin
    dec_in1   = '0;
    dec_in2   = '0;
    dec_store = '0;
    dec_aluop = ALU_ADD;
    dec_we    = 1'b0;
    dec_re    = 1'b0;
    dec_wm    = 1'b0;
    dec_ill   = 1'b0;
    // Every valid opcode ends in 2'b11, so a bad low pair falls into default.
    case (opcode)
      OPC_OP: begin
        dec_aluop = {instr[30], f3};
        dec_in1   = op1;
        dec_in2   = is_shift ? {27'b0, op2[4:0]} : op2;
        dec_we    = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] is part of the immediate except for the right shifts
        dec_aluop = {(f3 == 3'b101) ? instr[30] : 1'b0, f3};
        dec_in1   = op1;
        dec_in2   = is_shift ? {27'b0, instr[24:20]} : imm_i;
        dec_we    = 1'b1;
      end
      OPC_LOAD: begin
        dec_in1 = op1;
        dec_in2 = imm_i;
        dec_re  = 1'b1;
        dec_we  = 1'b1;
      end
      OPC_STORE: begin
        dec_in1   = op1;
        dec_in2   = imm_s;
        dec_store = op2;
        dec_wm    = 1'b1;
      end
      OPC_LUI: begin
        dec_in2 = imm_u;
        dec_we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_in1 = pc;
        dec_in2 = imm_u;
        dec_we  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4; the jump target is computed elsewhere.
        dec_in1 = pc;
        dec_in2 = 32'd4;
        dec_we  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_in1   = op1;
        dec_in2   = op2;
        dec_aluop = ALU_SUB;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
    if (rd_idx == 5'd0) begin
      dec_we = 1'b0;
    end
  end

  // Pipeline register
  logic        out_valid_q, out_valid_d;
  logic [31:0] alu_in1_q, alu_in1_d;
  logic [31:0] alu_in2_q, alu_in2_d;
  logic [3:0]  aluop_q, aluop_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic        illegal_q, illegal_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] store_data_q, store_data_d;
  logic        capture;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    aluop_d      = aluop_q;
    rd_d         = rd_q;
    reg_we_d     = reg_we_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    illegal_d    = illegal_q;
    funct3_d     = funct3_q;
    store_data_d = store_data_q;
    if (flush) begin
      // Side-effect flags are cleared so a killed slot can never write.
      out_valid_d = 1'b0;
      reg_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
    end else if (capture) begin
      out_valid_d  = 1'b1;
      alu_in1_d    = dec_in1;
      alu_in2_d    = dec_in2;
      aluop_d      = dec_aluop;
      rd_d         = rd_idx;
      reg_we_d     = dec_we;
      mem_re_d     = dec_re;
      mem_we_d     = dec_wm;
      illegal_d    = dec_ill;
      funct3_d     = f3;
      store_data_d = dec_store;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      aluop_q      <= ALU_ADD;
      rd_q         <= '0;
      reg_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      illegal_q    <= 1'b0;
      funct3_q     <= '0;
      store_data_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      aluop_q      <= aluop_d;
      rd_q         <= rd_d;
      reg_we_q     <= reg_we_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      illegal_q    <= illegal_d;
      funct3_q     <= funct3_d;
      store_data_q <= store_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign aluop      = aluop_q;
  assign rd         = rd_q;
  assign reg_we     = reg_we_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign illegal    = illegal_q;
  assign funct3     = funct3_q;
  assign store_data = store_data_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - testbench for id_ex_stage
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] sd;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        we;
    logic        re;
    logic        wm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        fwd_we = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, reg_we0, mem_re0, mem_we0, illegal0;
  logic [31:0] alu_in1_0, alu_in2_0, store_data0;
  logic [3:0]  aluop0;
  logic [4:0]  rd0;
  logic [2:0]  funct3_0;

  logic        in_ready1, out_valid1, reg_we1, mem_re1, mem_we1, illegal1;
  logic [31:0] alu_in1_1, alu_in2_1, store_data1;
  logic [3:0]  aluop1;
  logic [4:0]  rd1;
  logic [2:0]  funct3_1;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  id_ex_stage #(.FWD_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready),
    .alu_in1(alu_in1_0), .alu_in2(alu_in2_0), .aluop(aluop0), .rd(rd0),
    .reg_we(reg_we0), .mem_re(mem_re0), .mem_we(mem_we0), .illegal(illegal0),
    .funct3(funct3_0), .store_data(store_data0)
  );

  id_ex_stage #(.FWD_EN(0)) u_dut_nofwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready),
    .alu_in1(alu_in1_1), .alu_in2(alu_in2_1), .aluop(aluop1), .rd(rd1),
    .reg_we(reg_we1), .mem_re(mem_re1), .mem_we(mem_we1), .illegal(illegal1),
    .funct3(funct3_1), .store_data(store_data1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the RV32I field definitions.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic fwe, input logic [4:0] frd,
                                 input logic [31:0] fd, input bit fen);
    exp_t e;
    logic [31:0] a, b;
    logic [4:0] s1, s2;
    logic [2:0] f;
    s1 = ins[19:15];
    s2 = ins[24:20];
    f  = ins[14:12];
    a = (s1 == 0) ? 32'h0 : (fen && fwe && frd == s1) ? fd : r1;
    b = (s2 == 0) ? 32'h0 : (fen && fwe && frd == s2) ? fd : r2;
    e = '0;
    e.rd = ins[11:7];
    e.f3 = f;
    case (ins[6:0])
      7'h33: begin
        e.aluop = {ins[30], f};
        e.in1 = a;
        e.in2 = (f == 3'd1 || f == 3'd5) ? (b & 32'h1f) : b;
        e.we = 1;
      end
      7'h13: begin
        e.aluop = {(f == 3'd5) & ins[30], f};
        e.in1 = a;
        e.in2 = (f == 3'd1 || f == 3'd5) ? {27'b0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
        e.we = 1;
      end
      7'h03: begin e.in1 = a; e.in2 = {{20{ins[31]}}, ins[31:20]}; e.re = 1; e.we = 1; end
      7'h23: begin e.in1 = a; e.in2 = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.wm = 1; e.sd = b; end
      7'h37: begin e.in2 = {ins[31:12], 12'h0}; e.we = 1; end
      7'h17: begin e.in1 = p; e.in2 = {ins[31:12], 12'h0}; e.we = 1; end
      7'h6f, 7'h67: begin e.in1 = p; e.in2 = 32'd4; e.we = 1; end
      7'h63: begin e.in1 = a; e.in2 = b; e.aluop = 4'b1000; end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  task automatic cmp_out(input string who, input exp_t obs, input exp_t e);
    check({who, "_in1"}, obs.in1, e.in1);
    check({who, "_in2"}, obs.in2, e.in2);
    check({who, "_store_data"}, obs.sd, e.sd);
    check({who, "_aluop"}, {28'h0, obs.aluop}, {28'h0, e.aluop});
    check({who, "_rd"}, {27'h0, obs.rd}, {27'h0, e.rd});
    check({who, "_funct3"}, {29'h0, obs.f3}, {29'h0, e.f3});
    check({who, "_flags"}, {28'h0, obs.we, obs.re, obs.wm, obs.ill},
          {28'h0, e.we, e.re, e.wm, e.ill});
  endtask

  // Scoreboard: inputs are stable between the driving edge+1 and the next edge,
  // so the falling edge sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      check("sb_size", sb0.size(), 1);
      check("nofwd_valid", {31'h0, out_valid1}, 32'h1);
      if (sb0.size() > 0) begin
        cmp_out("sb_fwd", {alu_in1_0, alu_in2_0, store_data0, aluop0, rd0, funct3_0,
                           reg_we0, mem_re0, mem_we0, illegal0}, sb0.pop_front());
        cmp_out("sb_nofwd", {alu_in1_1, alu_in2_1, store_data1, aluop1, rd1, funct3_1,
                             reg_we1, mem_re1, mem_we1, illegal1}, sb1.pop_front());
      end
    end
    if (rst || flush) begin
      sb0.delete();
      sb1.delete();
    end else if (in_valid && in_ready0) begin
      check("nofwd_in_ready", {31'h0, in_ready1}, 32'h1);
      sb0.push_back(model(instr, pc, rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data, 1'b1));
      sb1.push_back(model(instr, pc, rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data, 1'b0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0] opc [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17,
                             7'h6f, 7'h67, 7'h63, 7'h7f, 7'h0b};

    // Reset with an instruction presented: it must be discarded.
    rst = 1; in_valid = 1; instr = 32'h002081B3; rs1_data = 5; rs2_data = 7;
    step(); step();
    check("rst_out_valid", {31'h0, out_valid0}, 0);
    check("rst_in1", alu_in1_0, 0);
    check("rst_in2", alu_in2_0, 0);
    check("rst_aluop", {28'h0, aluop0}, 0);
    check("rst_flags", {27'h0, reg_we0, mem_re0, mem_we0, illegal0, in_ready0}, 32'h1);
    rst = 0; in_valid = 0;
    step();
    check("rst_discard", {31'h0, out_valid0}, 0);

    // ADD x3,x1,x2
    in_valid = 1; instr = 32'h002081B3; rs1_data = 5; rs2_data = 7; pc = 32'h100;
    step();
    in_valid = 0;
    check("add_valid", {31'h0, out_valid0}, 1);
    check("add_in1", alu_in1_0, 5);
    check("add_in2", alu_in2_0, 7);
    check("add_aluop", {28'h0, aluop0}, 0);
    check("add_rd", {27'h0, rd0}, 3);
    check("add_we", {31'h0, reg_we0}, 1);
    step();
    check("consume_clear", {31'h0, out_valid0}, 0);

    // SRAI x5,x6,3
    in_valid = 1; instr = 32'h40335293; rs1_data = 32'h80000000;
    step();
    in_valid = 0;
    check("srai_in2", alu_in2_0, 3);
    check("srai_aluop", {28'h0, aluop0}, 32'hD);
    check("srai_we", {31'h0, reg_we0}, 1);
    step();

    // SW x2,8(x1) with x1 forwarded
    in_valid = 1; instr = 32'h0020A423; rs1_data = 32'h55; rs2_data = 32'h77;
    fwd_we = 1; fwd_rd = 1; fwd_data = 32'h100;
    step();
    in_valid = 0; fwd_we = 0;
    check("sw_in1_fwd", alu_in1_0, 32'h100);
    check("sw_in2", alu_in2_0, 8);
    check("sw_mem_we", {31'h0, mem_we0}, 1);
    check("sw_reg_we", {31'h0, reg_we0}, 0);
    check("sw_store_data", store_data0, 32'h77);
    check("sw_in1_nofwd", alu_in1_1, 32'h55);
    step();

    // Stall: ADDI x1,x0,5 held while XOR x4,x1,x2 waits
    out_ready = 0; in_valid = 1; instr = 32'h00500093;
    step();
    instr = 32'h0020C233; rs1_data = 32'hF0; rs2_data = 32'h0F;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", {31'h0, in_ready0}, 0);
      check("stall_in2", alu_in2_0, 5);
      check("stall_rd", {27'h0, rd0}, 1);
      check("stall_valid", {31'h0, out_valid0}, 1);
    end
    out_ready = 1;
    step();
    in_valid = 0;
    check("after_stall_aluop", {28'h0, aluop0}, 4);
    check("after_stall_rd", {27'h0, rd0}, 4);
    step();

    // Flush with an incoming instruction
    in_valid = 1; flush = 1; instr = 32'h002081B3;
    step();
    flush = 0; in_valid = 0;
    check("flush_in_valid", {31'h0, out_valid0}, 0);
    check("flush_we", {29'h0, reg_we0, mem_re0, mem_we0}, 0);
    // Flush of a held instruction
    out_ready = 0; in_valid = 1; instr = 32'h0020A423;
    step();
    in_valid = 0; flush = 1;
    step();
    flush = 0;
    check("flush_held_valid", {31'h0, out_valid0}, 0);
    check("flush_held_mem_we", {31'h0, mem_we0}, 0);

    // Reset in the middle of a stall
    in_valid = 1; instr = 32'h002081B3; rs1_data = 5; rs2_data = 7;
    step();
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    check("rst_stall_valid", {31'h0, out_valid0}, 0);
    check("rst_stall_in1", alu_in1_0, 0);
    check("rst_stall_in2", alu_in2_0, 0);
    check("rst_stall_rd", {27'h0, rd0}, 0);
    check("rst_stall_we", {31'h0, reg_we0}, 0);
    out_ready = 1;

    // Illegal word, then ADDI x0,x0,0
    in_valid = 1; instr = 32'hFFFFFFFF;
    step();
    check("ill_flag", {31'h0, illegal0}, 1);
    check("ill_ctrl", {29'h0, reg_we0, mem_we0, mem_re0}, 0);
    check("ill_valid", {31'h0, out_valid0}, 1);
    instr = 32'h00000013;
    step();
    in_valid = 0;
    check("nop_we", {31'h0, reg_we0}, 0);
    check("nop_valid", {31'h0, out_valid0}, 1);
    step();

    // Random traffic checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      instr = {r[31:7], opc[$urandom_range(0, 10)]};
      if ($urandom_range(0, 15) == 0) instr = $urandom();
      pc = $urandom();
      rs1_data = $urandom();
      rs2_data = $urandom();
      fwd_we = $urandom_range(0, 1);
      fwd_rd = $urandom_range(0, 1) ? instr[19:15] : ($urandom_range(0, 1) ? instr[24:20] : 5'($urandom()));
      fwd_data = $urandom();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 11) == 0);
      step();
    end

    // Drain
    in_valid = 0; flush = 0; out_ready = 1; fwd_we = 0;
    step(); step(); step();
    check("sb_drained", sb0.size(), 0);
    check("drained_valid", {31'h0, out_valid0}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
